reg_wb_queue: RTL
=================

# reg_wb_queue

Write-back queue between the execute stage and the register file. It accepts register write requests from two producers, the ALU and the memory-load path, through valid/ready handshakes. Requests are buffered in order in a small FIFO, and one write per cycle is issued on the register file's single write port (`we`/`addr`/`data`). An optional pending-write mask lets the issue logic detect read-after-write hazards.

## Interface
- `WIDTH`, 16, data width; matches the register file data width.
- `ADDR_WIDTH`, 4, register address width; the register count is `1 << ADDR_WIDTH`.
- `DEPTH`, 4, FIFO entries; must be a power of two and at least 2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `alu_valid`  in  1  ALU write request present.
- `alu_ready`  out  1  ALU request accepted this edge if `alu_valid`.
- `alu_addr`  in  ADDR_WIDTH  destination register.
- `alu_data`  in  WIDTH  result.
- `mem_valid`  in  1  load write request present.
- `mem_ready`  out  1  load request accepted this edge if `mem_valid`.
- `mem_addr`  in  ADDR_WIDTH  destination register.
- `mem_data`  in  WIDTH  load data.
- `hold`  in  1  suppresses popping; the register-file write port is borrowed elsewhere.
- `flush`  in  1  discards all queued entries.
- `rf_we`  out  1  registered; drives register file `we`.
- `rf_addr`  out  ADDR_WIDTH  registered; drives register file `addr`.
- `rf_data`  out  WIDTH  registered; drives register file `data`.
- `count`  out  $clog2(DEPTH)+1  occupied FIFO entries.
- `pending`  out  1<<ADDR_WIDTH  bit r set while a write to register r is queued or being issued.

## Operation
**Occupancy states** (derived from `count`):
- EMPTY: `count` = 0.
- PARTIAL: 0 < `count` < DEPTH.
- FULL: `count` = DEPTH.

**Ready logic** (combinational):
- `mem_ready` = `rst_n` & !`flush` & (`count` < DEPTH).
- `alu_ready` = `mem_ready` & !`mem_valid`.
- Loads have fixed priority; at most one push per cycle.
- No pass-through when FULL: a same-edge pop does not open a slot.

**Push:** an accepted request is written at the tail and the tail pointer increments, wrapping modulo DEPTH.

**Pop** (at each edge, with `rst_n`=1, `flush`=0, `hold`=0 and `count` > 0):
- The head entry loads into `rf_addr`/`rf_data` and `rf_we` is set to 1.
- The head pointer increments, wrapping modulo DEPTH.
- Otherwise `rf_we` is 0; `rf_addr`/`rf_data` keep their previous values.

**Push and pop on the same edge:** `count` is unchanged.

**Flush:**
- Head, tail and `count` clear to 0, and `rf_we` is 0 at the next edge.
- A write already on `rf_*` during the flush cycle completes normally, since the register file samples it on that edge.

**Ordering and duplicates:**
- Writes issue in acceptance order.
- Duplicate destinations are allowed; the last write wins.

**Reset** (`rst_n`=0 at an edge, including mid-drain):
- `count`=0, pointers 0, `rf_we`=0, `rf_addr`=0, `rf_data`=0, `pending`=0.
- Queued entries are lost.
- Ready outputs are 0 while `rst_n` is low.

## Timing
- Request accepted at edge k → `rf_we`=1 during cycle k+1..k+2 (with `hold`=0 and an empty queue) → register file updated at edge k+2.
- Sustained throughput: one write per cycle.
- `rf_we` is high for exactly one cycle per entry.
- `hold` stalls draining with no loss of data; inputs are still accepted until FULL.
- `pending` is combinational from FIFO valid entries plus the `rf_we`/`rf_addr` output stage. It updates in the cycle after acceptance and clears in the cycle after the last matching write has been issued to the register file.

## Configuration
- `REG_WB_PENDING_EN` defined: `pending` is the OR, over every valid FIFO entry and the active output stage, of the one-hot decode of that entry's address.
- Not defined: `pending` is tied to 0 and the decode logic is absent. All other behaviour is identical.

## Test plan
- ALU request r3=0x1234 at edge 1, queue empty → `rf_we`=1, `rf_addr`=3, `rf_data`=0x1234 during cycle 2..3 only; `count` returns to 0.
- `alu_valid` (r1, 0xAAAA) and `mem_valid` (r2, 0x5555) at the same edge → `mem_ready`=1, `alu_ready`=0; ALU accepted next edge; writes issue r2 then r1 on consecutive cycles.
- `hold`=1, push 4 ALU requests r4..r7 → `count`=4, both readies 0. A fifth request stalls. Release `hold` → r4..r7 issue in order, then the fifth request.
- `hold`=1, 3 entries queued, pulse `flush` → `count`=0, `pending`=0, no further `rf_we`; the next request is accepted normally.
- With `REG_WB_PENDING_EN`, queue r5=0x0001 and r5=0x0002 → `pending`[5]=1 until the second write issues; the final r5 value is 0x0002.
- `rst_n`=0 for one edge with 2 entries queued and `rf_we`=1 → all outputs reset to 0; no writes after reset.

Source files
------------

// File: rtl/reg_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module      : reg_wb_queue
//  Description : Write-back queue between the execute stage and the register
//                file. Accepts register writes from the ALU and the load path
//                (loads have priority), buffers them in order in a small FIFO
//                and issues one write per cycle on a registered rf_* port.
//                Optional macro REG_WB_PENDING_EN enables the pending-write
//                mask used for read-after-write hazard detection; when it is
//                undefined, `pending` is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_wb_queue #(
   parameter int WIDTH      = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int DEPTH      = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          alu_valid,
   output logic                          alu_ready,
   input  logic [ADDR_WIDTH-1:0]         alu_addr,
   input  logic [WIDTH-1:0]              alu_data,
   input  logic                          mem_valid,
   output logic                          mem_ready,
   input  logic [ADDR_WIDTH-1:0]         mem_addr,
   input  logic [WIDTH-1:0]              mem_data,
   input  logic                          hold,
   input  logic                          flush,
   output logic                          rf_we,
   output logic [ADDR_WIDTH-1:0]         rf_addr,
   output logic [WIDTH-1:0]              rf_data,
   output logic [$clog2(DEPTH):0]        count,
   output logic [(1<<ADDR_WIDTH)-1:0]    pending
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int NREG  = 1 << ADDR_WIDTH;

   localparam logic [CNT_W-1:0] c_full_count = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] c_ptr_one    = PTR_W'(1);
   localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

   // FIFO storage and pointers
   logic [ADDR_WIDTH-1:0] r_addr_mem [DEPTH];
   logic [WIDTH-1:0]      r_data_mem [DEPTH];
   logic [PTR_W-1:0]      r_head;
   logic [PTR_W-1:0]      r_tail;
   logic [CNT_W-1:0]      r_count;

   // Registered write-port stage
   logic                  r_rf_we;
   logic [ADDR_WIDTH-1:0] r_rf_addr;
   logic [WIDTH-1:0]      r_rf_data;

   // Handshake / control wires
   logic                  w_empty;
   logic                  w_full;
   logic                  w_mem_ready;
   logic                  w_alu_ready;
   logic                  w_push;
   logic                  w_pop;
   logic [ADDR_WIDTH-1:0] w_push_addr;
   logic [WIDTH-1:0]      w_push_data;

   // Occupancy decode, ready generation and push/pop qualification.
   // Readiness depends only on the current count, so a pop on the same edge
   // never opens a slot for a request while the queue is full.
   always_comb begin
      w_empty     = (r_count == '0);
      w_full      = (r_count == c_full_count);
      w_mem_ready = rst_n & ~flush & ~w_full;
      w_alu_ready = w_mem_ready & ~mem_valid;
      w_push      = (mem_valid & w_mem_ready) | (alu_valid & w_alu_ready);
      w_push_addr = mem_valid ? mem_addr : alu_addr;
      w_push_data = mem_valid ? mem_data : alu_data;
      w_pop       = ~flush & ~hold & ~w_empty;
   end

   // Entry storage; writes are gated by the ready logic, which is low in reset
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr_mem[r_tail] <= w_push_addr;
         r_data_mem[r_tail] <= w_push_data;
      end
   end

   // Pointers, occupancy and the registered register-file write stage
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_head    <= '0;
         r_tail    <= '0;
         r_count   <= '0;
         r_rf_we   <= 1'b0;
         r_rf_addr <= '0;
         r_rf_data <= '0;
      end else if (flush) begin
         // A write already on rf_* completes at this edge by itself
         r_head    <= '0;
         r_tail    <= '0;
         r_count   <= '0;
         r_rf_we   <= 1'b0;
      end else begin
         if (w_push) begin
            r_tail <= r_tail + c_ptr_one;
         end
         if (w_pop) begin
            r_head    <= r_head + c_ptr_one;
            r_rf_we   <= 1'b1;
            r_rf_addr <= r_addr_mem[r_head];
            r_rf_data <= r_data_mem[r_head];
         end else begin
            r_rf_we   <= 1'b0;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_cnt_one;
            2'b01:   r_count <= r_count - c_cnt_one;
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef REG_WB_PENDING_EN
   logic [DEPTH-1:0] w_slot_valid;
   logic [NREG-1:0]  w_pending;

   // A slot holds a live entry when its distance from the head is below count
   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_slot
         logic [PTR_W-1:0] w_slot_off;
         assign w_slot_off      = PTR_W'(i) - r_head;
         assign w_slot_valid[i] = ({1'b0, w_slot_off} < r_count);
      end
   endgenerate

   // OR of one-hot destination decodes over live entries and the output stage
   always_comb begin
      w_pending = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_slot_valid[i]) begin
            w_pending[r_addr_mem[i]] = 1'b1;
         end
      end
      if (r_rf_we) begin
         w_pending[r_rf_addr] = 1'b1;
      end
   end

   assign pending = w_pending;
`else
   assign pending = '0;
`endif

   assign mem_ready = w_mem_ready;
   assign alu_ready = w_alu_ready;
   assign rf_we     = r_rf_we;
   assign rf_addr   = r_rf_addr;
   assign rf_data   = r_rf_data;
   assign count     = r_count;

endmodule
`default_nettype wire
